// File: rtl/mant_div_seq.sv
// mant_div_seq -- sequential restoring divider for floating-point significands.
//
// Divides A = {1,m1} by B = {1,m2} one quotient bit per cycle, then normalises
// and rounds the quotient to a WIDTH-bit fraction (hidden 1 removed).
//
// Ports:
//   clk                 rising-edge clock
//   reset               asynchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready only while idle)
//   m1, m2              dividend / divisor fractions
//   rm                  rounding mode: 00 RNE, 01 RTZ, 10 RAZ, 11 RNE
//   flush               synchronous abort, returns to idle with cleared outputs
//   out_valid/out_ready result handshake; result held until taken
//   m3                  rounded quotient fraction
//   decrement_exponent  quotient was below 1.0
//   inexact             guard or sticky bit was set before rounding
module mant_div_seq #(
   parameter int WIDTH = 23
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] m1,
   input  logic [WIDTH-1:0] m2,
   input  logic [1:0]       rm,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] m3,
   output logic             decrement_exponent,
   output logic             inexact
);

   localparam int QW = WIDTH + 3;            // quotient bits: integer bit + WIDTH+2 fraction
   localparam int RW = WIDTH + 2;            // remainder width, room for 2R
   localparam int CW = $clog2(WIDTH + 3);    // counter holds WIDTH+2

   typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [QW-1:0]    q_q;
   logic [RW-1:0]    r_q;
   logic [RW-1:0]    b_q;
   logic [1:0]       rm_q;
   logic [WIDTH-1:0] m3_q;
   logic             dec_q;
   logic             inexact_q;

   // One restoring step. The very first step (counter still at its load
   // value) compares A itself, giving the integer bit of the quotient.
   logic [RW-1:0] r_shift;
   logic [RW-1:0] r_d;
   logic          q_bit;

   always_comb begin
      r_shift = (cnt_q == CW'(WIDTH + 2)) ? r_q : {r_q[RW-2:0], 1'b0};
      q_bit   = (r_shift >= b_q);
      r_d     = q_bit ? (r_shift - b_q) : r_shift;
   end

   // Normalisation and rounding of the finished quotient.
   logic [WIDTH-1:0] frac;
   logic             guard;
   logic             sticky;
   logic             norm_dec;
   logic             inc;
   logic [WIDTH-1:0] m3_d;
   logic             round_carry;

   always_comb begin
      if (q_q[QW-1]) begin
         frac     = q_q[QW-2:2];
         guard    = q_q[1];
         sticky   = q_q[0] | (|r_q);
         norm_dec = 1'b0;
      end else begin
         frac     = q_q[QW-3:1];
         guard    = q_q[0];
         sticky   = |r_q;
         norm_dec = 1'b1;
      end
      case (rm_q)
         2'b01:   inc = 1'b0;
         2'b10:   inc = guard | sticky;
         default: inc = guard & (sticky | frac[0]);
      endcase
      {round_carry, m3_d} = {1'b0, frac} + {{WIDTH{1'b0}}, inc};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         q_q       <= '0;
         r_q       <= '0;
         b_q       <= '0;
         rm_q      <= '0;
         m3_q      <= '0;
         dec_q     <= 1'b0;
         inexact_q <= 1'b0;
      end else if (flush) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         q_q       <= '0;
         r_q       <= '0;
         b_q       <= '0;
         rm_q      <= '0;
         m3_q      <= '0;
         dec_q     <= 1'b0;
         inexact_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  b_q     <= RW'({1'b1, m2});
                  r_q     <= RW'({1'b1, m1});
                  rm_q    <= rm;
                  q_q     <= '0;
                  cnt_q   <= CW'(WIDTH + 2);
                  state_q <= DIVIDE;
               end
            end
            DIVIDE: begin
               q_q <= {q_q[QW-2:0], q_bit};
               r_q <= r_d;
               if (cnt_q == '0) begin
                  state_q <= ROUND;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            ROUND: begin
               m3_q      <= m3_d;
               dec_q     <= norm_dec;
               inexact_q <= guard | sticky;
               state_q   <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // A legal significand quotient is below 2.0, so rounding never overflows
   // the fraction field.
   assert property (@(posedge clk) disable iff (reset)
                    (state_q == ROUND) |-> !round_carry);

   assign in_ready           = (state_q == IDLE);
   assign out_valid          = (state_q == DONE);
   assign m3                 = m3_q;
   assign decrement_exponent = dec_q;
   assign inexact            = inexact_q;

endmodule
